// File: rtl/neokeon_pkg.sv
// rtl/neokeon_pkg.sv - shared constants and types for the Neokeon Gamma datapath
package neokeon_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int STATE_W    = 4 * WORD_W_DEF;

  // Word index within the state vector; a0 sits in the MSBs.
  localparam int A0 = 0;
  localparam int A1 = 1;
  localparam int A2 = 2;
  localparam int A3 = 3;

  localparam logic [STATE_W-1:0] GAMMA_ZERO_IN  = '0;
  localparam logic [STATE_W-1:0] GAMMA_ZERO_OUT = {{(3*WORD_W_DEF){1'b1}}, {WORD_W_DEF{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NL1,
    ST_NL2,
    ST_HOLD
  } gamma_state_e;

endpackage

// File: rtl/neokeon_gamma_nl.sv
// rtl/neokeon_gamma_nl.sv - combinational Neokeon Gamma nonlinear step
module neokeon_gamma_nl
  import neokeon_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic [4*WORD_W-1:0] din,
  output logic [4*WORD_W-1:0] dout
);

  localparam int L0 = (3 - A0) * WORD_W;
  localparam int L1 = (3 - A1) * WORD_W;
  localparam int L2 = (3 - A2) * WORD_W;
  localparam int L3 = (3 - A3) * WORD_W;

  logic [WORD_W-1:0] a0, a1, a2, a3, a0_n, a1_n;

  assign a0 = din[L0 +: WORD_W];
  assign a1 = din[L1 +: WORD_W];
  assign a2 = din[L2 +: WORD_W];
  assign a3 = din[L3 +: WORD_W];

  // a0 update uses the already-updated a1
  assign a1_n = a1 ^ (~a3 & ~a2);
  assign a0_n = a0 ^ (a2 & a1_n);

  assign dout = {a0_n, a1_n, a2, a3};

endmodule

// File: rtl/neokeon_gamma_pipe.sv
// rtl/neokeon_gamma_pipe.sv - back-pressurable Neokeon Gamma; NEOKEON_GAMMA_AREA_EN selects the iterative build
module neokeon_gamma_pipe
  import neokeon_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inValid,
  output logic                inReady,
  input  logic [4*WORD_W-1:0] inDataState,
  output logic                outValid,
  input  logic                outReady,
  output logic [4*WORD_W-1:0] outDataState,
  output logic                busy
);

  localparam int SW = 4 * WORD_W;
  localparam int L0 = (3 - A0) * WORD_W;
  localparam int L1 = (3 - A1) * WORD_W;
  localparam int L2 = (3 - A2) * WORD_W;
  localparam int L3 = (3 - A3) * WORD_W;

  generate
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
      $error("neokeon_gamma_pipe: STAGES must be in 1..3");
    end
  endgenerate

  // Linear mix: swap a0/a3, then fold every word into a2.
  logic [SW-1:0]     lin_in, lin_out;
  logic [WORD_W-1:0] l0, l1, l2, l3;

  assign l0 = lin_in[L0 +: WORD_W];
  assign l1 = lin_in[L1 +: WORD_W];
  assign l2 = lin_in[L2 +: WORD_W];
  assign l3 = lin_in[L3 +: WORD_W];
  assign lin_out = {l3, l1, l2 ^ l3 ^ l1 ^ l0, l0};

`ifdef NEOKEON_GAMMA_AREA_EN

  gamma_state_e  state_q, state_d;
  logic [SW-1:0] work_q, nl_out;
  logic          load_in, load_nl1, load_nl2;

  neokeon_gamma_nl #(.WORD_W(WORD_W)) u_nl (.din(work_q), .dout(nl_out));

  assign lin_in       = nl_out;
  assign outDataState = work_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    inReady  = 1'b0;
    outValid = 1'b0;
    busy     = 1'b1;
    load_in  = 1'b0;
    load_nl1 = 1'b0;
    load_nl2 = 1'b0;
    case (state_q)
      ST_IDLE: begin
        inReady = 1'b1;
        busy    = 1'b0;
        if (inValid) begin
          load_in = 1'b1;
          state_d = ST_NL1;
        end
      end
      ST_NL1: begin
        load_nl1 = 1'b1;
        state_d  = ST_NL2;
      end
      ST_NL2: begin
        load_nl2 = 1'b1;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        outValid = 1'b1;
        if (outReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
    end else if (load_in) begin
      work_q <= inDataState;
    end else if (load_nl1) begin
      work_q <= lin_out;
    end else if (load_nl2) begin
      work_q <= nl_out;
    end
  end

`else

  logic [SW-1:0]              nl_a_out, nl_b_in, nl_b_out;
  logic [STAGES-1:0][SW-1:0]  stage_d, stage_nxt;
  logic [STAGES-1:0]          stage_v;
  logic [STAGES:0]            rdy, vchain;

  neokeon_gamma_nl #(.WORD_W(WORD_W)) u_nl_a (.din(inDataState), .dout(nl_a_out));
  neokeon_gamma_nl #(.WORD_W(WORD_W)) u_nl_b (.din(nl_b_in),     .dout(nl_b_out));

  // Where the register cuts fall between NL, linear and NL.
  generate
    if (STAGES == 1) begin : g_map1
      assign lin_in       = nl_a_out;
      assign nl_b_in      = lin_out;
      assign stage_nxt[0] = nl_b_out;
    end else if (STAGES == 2) begin : g_map2
      assign lin_in       = nl_a_out;
      assign stage_nxt[0] = lin_out;
      assign nl_b_in      = stage_d[0];
      assign stage_nxt[1] = nl_b_out;
    end else begin : g_map3
      assign stage_nxt[0] = nl_a_out;
      assign lin_in       = stage_d[0];
      assign stage_nxt[1] = lin_out;
      assign nl_b_in      = stage_d[1];
      assign stage_nxt[2] = nl_b_out;
    end
  endgenerate

  assign vchain = {stage_v, inValid};

  // A stage can take new data when empty or when everything downstream drains.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = outReady;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = ~stage_v[k] | rdy[k+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_v            <= '0;
      stage_d[STAGES-1]  <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          stage_v[k] <= vchain[k];
          if (vchain[k]) stage_d[k] <= stage_nxt[k];
        end
      end
    end
  end

  assign inReady      = rdy[0];
  assign outValid     = stage_v[STAGES-1];
  assign outDataState = stage_d[STAGES-1];
  assign busy         = |stage_v;

`endif

endmodule

// File: tb/tb_neokeon_gamma_pipe.sv
// tb/tb_neokeon_gamma_pipe.sv - directed self-checking bench for neokeon_gamma_pipe
module tb_neokeon_gamma_pipe;
  import neokeon_pkg::*;

`ifdef NEOKEON_GAMMA_AREA_EN
  localparam int LAT2 = 3;
  localparam int LAT3 = 3;
`else
  localparam int LAT2 = 2;
  localparam int LAT3 = 3;
`endif

  logic clk, rst;
  logic iv2, ir2, ov2, or2, b2;
  logic [127:0] id2, od2;
  logic iv3, ir3, ov3, or3, b3;
  logic [127:0] id3, od3;
  logic ivc, irc, mv, mr, ovc, orc, bc1, bc2;
  logic [127:0] idc, md, odc;

  int checks = 0;
  int failures = 0;

  neokeon_gamma_pipe #(.WORD_W(32), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .inValid(iv2), .inReady(ir2), .inDataState(id2),
    .outValid(ov2), .outReady(or2), .outDataState(od2), .busy(b2));

  neokeon_gamma_pipe #(.WORD_W(32), .STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .inValid(iv3), .inReady(ir3), .inDataState(id3),
    .outValid(ov3), .outReady(or3), .outDataState(od3), .busy(b3));

  neokeon_gamma_pipe #(.WORD_W(32), .STAGES(1)) chain1 (
    .clk(clk), .rst(rst), .inValid(ivc), .inReady(irc), .inDataState(idc),
    .outValid(mv), .outReady(mr), .outDataState(md), .busy(bc1));

  neokeon_gamma_pipe #(.WORD_W(32), .STAGES(2)) chain2 (
    .clk(clk), .rst(rst), .inValid(mv), .inReady(mr), .inDataState(md),
    .outValid(ovc), .outReady(orc), .outDataState(odc), .busy(bc2));

  always #5 clk = ~clk;

  // Per-bit 4-bit S-box of Gamma, hand-derived; index {a0,a1,a2,a3}, nibble n at bits [4n+:4].
  function automatic logic [127:0] gamma_ref(input logic [127:0] s);
    logic [63:0]  tbl;
    logic [3:0]   n, r;
    logic [127:0] o;
    tbl = 64'h6073_B195_DF84_C2AE;
    o = '0;
    for (int i = 0; i < 32; i++) begin
      n = {s[96+i], s[64+i], s[32+i], s[i]};
      r = tbl[int'(n)*4 +: 4];
      o[96+i] = r[3];
      o[64+i] = r[2];
      o[32+i] = r[1];
      o[i]    = r[0];
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", ov2); end
    checks++; if (ir2 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", ir2); end
    checks++; if (b2 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", b2); end
    checks++; if (od2 !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", od2); end
    checks++; if (ov3 !== 1'b0 || ir3 !== 1'b1) begin failures++; $display("FAIL reset_dut3 got v=%0b r=%0b exp v=0 r=1", ov3, ir3); end
  endtask

  task automatic test_vector(input logic [127:0] vin, input logic [127:0] vexp, input string name);
    or2 = 1'b1;
    iv2 = 1'b1;
    id2 = vin;
    #1;
    checks++; if (ir2 !== 1'b1) begin failures++; $display("FAIL %s_in_ready got=%0b exp=1", name, ir2); end
    tick();
    iv2 = 1'b0;
    id2 = ~vin;
    for (int c = 1; c < LAT2; c++) begin
      checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL %s_early_valid cycle=%0d got=%0b exp=0", name, c, ov2); end
      tick();
    end
    checks++; if (ov2 !== 1'b1) begin failures++; $display("FAIL %s_valid_at_latency got=%0b exp=1", name, ov2); end
    checks++; if (od2 !== vexp) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, od2, vexp); end
    tick();
    checks++; if (ov2 !== 1'b0 || b2 !== 1'b0) begin failures++; $display("FAIL %s_drain got v=%0b busy=%0b exp 0 0", name, ov2, b2); end
  endtask

`ifdef NEOKEON_GAMMA_AREA_EN
  task automatic test_area_fsm();
    logic [127:0] held;
    or2 = 1'b0;
    iv2 = 1'b1;
    id2 = 128'h0;
    #1;
    checks++; if (ir2 !== 1'b1) begin failures++; $display("FAIL area_idle_ready got=%0b exp=1", ir2); end
    tick();
    iv2 = 1'b1;
    id2 = 128'hDEAD;
    for (int c = 0; c < 2; c++) begin
      checks++; if (ir2 !== 1'b0 || ov2 !== 1'b0 || b2 !== 1'b1) begin failures++;
        $display("FAIL area_busy_phase cycle=%0d got r=%0b v=%0b busy=%0b exp r=0 v=0 busy=1", c, ir2, ov2, b2); end
      tick();
    end
    checks++; if (ov2 !== 1'b1 || od2 !== GAMMA_ZERO_OUT) begin failures++;
      $display("FAIL area_result got v=%0b d=%h exp v=1 d=%h", ov2, od2, GAMMA_ZERO_OUT); end
    held = od2;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (ov2 !== 1'b1 || od2 !== GAMMA_ZERO_OUT || ir2 !== 1'b0) begin failures++;
        $display("FAIL area_hold cycle=%0d got v=%0b r=%0b d=%h exp v=1 r=0 d=%h", c, ov2, ir2, od2, held); end
    end
    iv2 = 1'b0;
    or2 = 1'b1;
    tick();
    checks++; if (ov2 !== 1'b0 || ir2 !== 1'b1 || b2 !== 1'b0) begin failures++;
      $display("FAIL area_release got v=%0b r=%0b busy=%0b exp v=0 r=1 busy=0", ov2, ir2, b2); end
  endtask
`else
  task automatic test_streaming();
    logic [127:0] vec [10];
    int n_acc, n_out;
    logic exp_v;
    for (int i = 0; i < 10; i++) begin
      vec[i] = {32'h0123_4567 ^ i, 32'h89AB_CDEF, 32'hDEAD_BEEF ^ (i << 8), 32'hFFFF_0000 >> i};
    end
    vec[0] = '1;
    n_acc = 0;
    n_out = 0;
    or3 = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      iv3 = (n_acc < 10);
      if (n_acc < 10) id3 = vec[n_acc];
      #1;
      if (iv3) begin
        checks++; if (ir3 !== 1'b1) begin failures++; $display("FAIL stream_in_ready cycle=%0d got=%0b exp=1", cyc, ir3); end
      end
      if (iv3 && ir3) n_acc++;
      tick();
      exp_v = (cyc >= LAT3 - 1) && (cyc < LAT3 + 9);
      checks++; if (ov3 !== exp_v) begin failures++; $display("FAIL stream_valid cycle=%0d got=%0b exp=%0b", cyc, ov3, exp_v); end
      if (ov3 === 1'b1 && exp_v && n_out < 10) begin
        checks++; if (od3 !== gamma_ref(vec[n_out])) begin failures++;
          $display("FAIL stream_data idx=%0d got=%h exp=%h", n_out, od3, gamma_ref(vec[n_out])); end
        n_out++;
      end
    end
    iv3 = 1'b0;
    checks++; if (od3 !== 128'h0 && n_out == 0) begin failures++; $display("FAIL stream_none_seen got=%0d exp=10", n_out); end
    checks++; if (gamma_ref(vec[0]) !== {32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0} || n_out != 10) begin failures++;
      $display("FAIL stream_count got=%0d exp=10", n_out); end
  endtask

  task automatic test_backpressure();
    logic [127:0] bp [3];
    int n_acc;
    bp[0] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    bp[1] = 128'hF0F0_0F0F_AAAA_5555_CCCC_3333_0000_FFFF;
    bp[2] = 128'h0;
    n_acc = 0;
    or2 = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      iv2 = 1'b1;
      id2 = bp[n_acc];
      #1;
      checks++; if (ir2 !== (cyc < 2)) begin failures++; $display("FAIL bp_in_ready cycle=%0d got=%0b exp=%0b", cyc, ir2, cyc < 2); end
      if (ir2) n_acc++;
      tick();
      if (cyc == 0) begin
        checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL bp_early_valid got=%0b exp=0", ov2); end
      end else begin
        checks++; if (ov2 !== 1'b1 || od2 !== gamma_ref(bp[0])) begin failures++;
          $display("FAIL bp_hold cycle=%0d got v=%0b d=%h exp v=1 d=%h", cyc, ov2, od2, gamma_ref(bp[0])); end
      end
    end
    iv2 = 1'b0;
    or2 = 1'b1;
    tick();
    checks++; if (ov2 !== 1'b1 || od2 !== gamma_ref(bp[1])) begin failures++;
      $display("FAIL bp_second got v=%0b d=%h exp v=1 d=%h", ov2, od2, gamma_ref(bp[1])); end
    tick();
    checks++; if (ov2 !== 1'b0 || b2 !== 1'b0) begin failures++; $display("FAIL bp_drain got v=%0b busy=%0b exp 0 0", ov2, b2); end
  endtask
`endif

  task automatic test_reset_mid();
    or3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv3 = 1'b1;
      id3 = {4{32'hA5A5_0000 | i}};
      tick();
    end
    iv3 = 1'b0;
    checks++; if (b3 !== 1'b1) begin failures++; $display("FAIL rstmid_inflight got busy=%0b exp=1", b3); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (b3 !== 1'b0 || ov3 !== 1'b0) begin failures++; $display("FAIL rstmid_cleared got busy=%0b v=%0b exp 0 0", b3, ov3); end
    or3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL rstmid_stale cycle=%0d got v=%0b exp=0", i, ov3); end
    end
  endtask

  task automatic test_random_chain();
    logic [127:0] q [$];
    logic [127:0] cur, exp_d;
    int sent, got;
    sent = 0;
    got = 0;
    orc = 1'b1;
    cur = {$urandom, $urandom, $urandom, $urandom};
    for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
      ivc = (sent < 100);
      idc = cur;
      #1;
      if (ivc && irc) begin
        q.push_back(cur);
        sent++;
        cur = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      if (ovc === 1'b1) begin
        exp_d = (q.size() > 0) ? q.pop_front() : ~odc;
        checks++; if (odc !== exp_d) begin failures++; $display("FAIL chain_involution idx=%0d got=%h exp=%h", got, odc, exp_d); end
        got++;
      end
    end
    ivc = 1'b0;
    checks++; if (got != 100) begin failures++; $display("FAIL chain_count got=%0d exp=100", got); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    iv2 = 1'b0; or2 = 1'b1; id2 = '0;
    iv3 = 1'b0; or3 = 1'b1; id3 = '0;
    ivc = 1'b0; orc = 1'b1; idc = '0;
    test_reset();
    test_vector(GAMMA_ZERO_IN, GAMMA_ZERO_OUT, "zero");
    test_vector(GAMMA_ZERO_OUT, GAMMA_ZERO_IN, "involution");
    test_vector('1, {32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0}, "ones");
`ifdef NEOKEON_GAMMA_AREA_EN
    test_area_fsm();
`else
    test_streaming();
    test_backpressure();
`endif
    test_reset_mid();
    test_random_chain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
